mux8_reg: RTL and testbench

- Registered 8-to-1 multiplexer: selects one of eight WIDTH-bit data inputs (i0..i7) using a 3-bit select formed from s2 (MSB), s1, s0 (LSB).
- The selected word is captured into an output register each clock.
- Used as a generic data-select stage in the datapath.
- Combinational select core plus one output pipeline register with synchronous reset.

---
 rtl/mux8_reg_pkg.sv | 9 +
 rtl/mux8_core.sv | 33 +++
 rtl/mux8_reg.sv | 55 +++++
 tb/tb_mux8_reg.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mux8_reg_pkg.sv
// Shared definitions for the registered 8:1 select stage.
package mux8_reg_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Select code assembled as {s2, s1, s0}; all eight values are legal.
    typedef logic [2:0] sel_t;

endpackage : mux8_reg_pkg

// File: rtl/mux8_core.sv
// Combinational 8:1 word select; no state.
module mux8_core
    import mux8_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  sel_t             sel_i,
    input  logic [WIDTH-1:0] i0_i,
    input  logic [WIDTH-1:0] i1_i,
    input  logic [WIDTH-1:0] i2_i,
    input  logic [WIDTH-1:0] i3_i,
    input  logic [WIDTH-1:0] i4_i,
    input  logic [WIDTH-1:0] i5_i,
    input  logic [WIDTH-1:0] i6_i,
    input  logic [WIDTH-1:0] i7_i,
    output logic [WIDTH-1:0] y_o
);

    // Every code is covered, so no default arm is needed to avoid a latch.
    always_comb begin
        unique case (sel_i)
            3'd0: y_o = i0_i;
            3'd1: y_o = i1_i;
            3'd2: y_o = i2_i;
            3'd3: y_o = i3_i;
            3'd4: y_o = i4_i;
            3'd5: y_o = i5_i;
            3'd6: y_o = i6_i;
            3'd7: y_o = i7_i;
        endcase
    end

endmodule : mux8_core

// File: rtl/mux8_reg.sv
// Registered 8:1 multiplexer: one-cycle select stage with synchronous reset on y.
module mux8_reg
    import mux8_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [WIDTH-1:0] i4,
    input  logic [WIDTH-1:0] i5,
    input  logic [WIDTH-1:0] i6,
    input  logic [WIDTH-1:0] i7,
    input  logic             s2,
    input  logic             s1,
    input  logic             s0,
    output logic [WIDTH-1:0] y
);

    sel_t             sel;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;

    assign sel = {s2, s1, s0};

    mux8_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .sel_i(sel),
        .i0_i (i0),
        .i1_i (i1),
        .i2_i (i2),
        .i3_i (i3),
        .i4_i (i4),
        .i5_i (i5),
        .i6_i (i6),
        .i7_i (i7),
        .y_o  (y_d)
    );

    // Output stage: reset wins over capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule : mux8_reg

// File: tb/tb_mux8_reg.sv
// Directed bench for mux8_reg at WIDTH=4 and WIDTH=8 driven side by side.
module tb_mux8_reg;

    logic       clk;
    logic       rst;
    logic [2:0] sel;
    logic [3:0] d4 [8];
    logic [7:0] d8 [8];
    logic [3:0] y4;
    logic [7:0] y8;

    int n_cmp;
    int n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux8_reg #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .i0(d4[0]), .i1(d4[1]), .i2(d4[2]), .i3(d4[3]),
        .i4(d4[4]), .i5(d4[5]), .i6(d4[6]), .i7(d4[7]),
        .s2(sel[2]), .s1(sel[1]), .s0(sel[0]),
        .y(y4)
    );

    mux8_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .i0(d8[0]), .i1(d8[1]), .i2(d8[2]), .i3(d8[3]),
        .i4(d8[4]), .i5(d8[5]), .i6(d8[6]), .i7(d8[7]),
        .s2(sel[2]), .s1(sel[1]), .s0(sel[0]),
        .y(y8)
    );

    typedef struct {
        logic       rst;
        logic [2:0] sel;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_odd();
        for (int k = 0; k < 8; k++) begin
            d4[k] = 4'(2 * k + 1);
            d8[k] = 8'(2 * k + 1);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        sel   = 3'b101;
        load_odd();

        vecs[0]  = '{1'b1, 3'd5, 8'd0,  "reset_edge1"};
        vecs[1]  = '{1'b1, 3'd5, 8'd0,  "reset_edge2"};
        vecs[2]  = '{1'b0, 3'd0, 8'd1,  "sweep_0"};
        vecs[3]  = '{1'b0, 3'd1, 8'd3,  "sweep_1"};
        vecs[4]  = '{1'b0, 3'd2, 8'd5,  "sweep_2"};
        vecs[5]  = '{1'b0, 3'd3, 8'd7,  "sweep_3"};
        vecs[6]  = '{1'b0, 3'd4, 8'd9,  "sweep_4"};
        vecs[7]  = '{1'b0, 3'd5, 8'd11, "sweep_5"};
        vecs[8]  = '{1'b0, 3'd6, 8'd13, "sweep_6"};
        vecs[9]  = '{1'b0, 3'd7, 8'd15, "sweep_7"};
        vecs[10] = '{1'b0, 3'd0, 8'd1,  "mid_0"};
        vecs[11] = '{1'b0, 3'd1, 8'd3,  "mid_1"};
        vecs[12] = '{1'b0, 3'd2, 8'd5,  "mid_2"};
        vecs[13] = '{1'b0, 3'd3, 8'd7,  "mid_3"};
        vecs[14] = '{1'b1, 3'd4, 8'd0,  "mid_rst_at_4"};
        vecs[15] = '{1'b0, 3'd6, 8'd13, "mid_release_6"};

        @(negedge clk);
        for (int v = 0; v < 16; v++) begin
            rst = vecs[v].rst;
            sel = vecs[v].sel;
            tick();
            chk({vecs[v].name, "_w4"}, {4'h0, y4}, vecs[v].exp);
            chk({vecs[v].name, "_w8"}, y8, vecs[v].exp);
        end

        // Latency: y must not move until the edge after sel changes.
        rst = 1'b0;
        sel = 3'b000;
        tick();
        chk("lat_pre", {4'h0, y4}, 8'd1);
        sel = 3'b111;
        #3;
        chk("lat_mid_cycle", {4'h0, y4}, 8'd1);
        chk("lat_mid_cycle_w8", y8, 8'd1);
        tick();
        chk("lat_post", {4'h0, y4}, 8'd15);
        chk("lat_post_w8", y8, 8'd15);

        // Isolation: non-selected inputs churn, selected i2 held at 5.
        sel = 3'b010;
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < 8; k++) begin
                if (k != 2) begin
                    d4[k] = 4'($urandom);
                    d8[k] = 8'($urandom);
                end
            end
            d4[2] = 4'd5;
            d8[2] = 8'd5;
            tick();
            chk("isolation_w4", {4'h0, y4}, 8'd5);
            chk("isolation_w8", y8, 8'd5);
        end

        // Width extremes: all-ones vs all-zeros, alternating every cycle.
        d4[7] = 4'hF;  d4[0] = 4'h0;
        d8[7] = 8'hFF; d8[0] = 8'h00;
        for (int c = 0; c < 6; c++) begin
            sel = (c % 2 == 0) ? 3'b111 : 3'b000;
            tick();
            chk("extreme_w4", {4'h0, y4}, (c % 2 == 0) ? 8'h0F : 8'h00);
            chk("extreme_w8", y8, (c % 2 == 0) ? 8'hFF : 8'h00);
        end

        // Multi-cycle reset hold, then clean release.
        rst = 1'b1;
        sel = 3'b111;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_hold_w4", {4'h0, y4}, 8'h00);
            chk("rst_hold_w8", y8, 8'h00);
        end
        rst = 1'b0;
        tick();
        chk("rst_release_w4", {4'h0, y4}, 8'h0F);
        chk("rst_release_w8", y8, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mux8_reg
